// File: rtl/modboard_route_pkg.sv
// Shared types and helpers for the modboard pin router.
package modboard_route_pkg;

  localparam int unsigned N_IN_DEF     = 8;
  localparam int unsigned N_OUT_DEF    = 4;
  localparam int unsigned DEAD_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    DEAD  = 2'd2,
    MAKE  = 2'd3
  } route_state_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  // Frame layout, MSB first: out_idx | en | src.
  function automatic int unsigned frame_w(input int unsigned oidx_w, input int unsigned sel_w);
    return oidx_w + 1 + sel_w;
  endfunction

  function automatic int unsigned src_lsb();
    return 0;
  endfunction

  function automatic int unsigned en_pos(input int unsigned sel_w);
    return sel_w;
  endfunction

  function automatic int unsigned oidx_lsb(input int unsigned sel_w);
    return sel_w + 1;
  endfunction

endpackage

// File: rtl/modboard_route_spi_rx.sv
// Serial config receiver: synchronises the MCU port, shifts frames in and
// reports each completed frame as a one-cycle valid or error pulse.
module modboard_route_spi_rx
  import modboard_route_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned OIDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cs_n,
  input  logic              cfg_sck,
  input  logic              cfg_sdi,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [OIDX_W-1:0] frame_oidx,
  output logic              frame_en,
  output logic [SEL_W-1:0]  frame_src
);

  localparam int unsigned FRAME_W  = frame_w(OIDX_W, SEL_W);
  localparam int unsigned CNT_MAX  = FRAME_W + 1;
  localparam int unsigned CNT_W    = clog2(FRAME_W + 2);
  localparam int unsigned SRC_LSB  = src_lsb();
  localparam int unsigned EN_POS   = en_pos(SEL_W);
  localparam int unsigned OIDX_LSB = oidx_lsb(SEL_W);

  logic [1:0]         cs_sync;
  logic [1:0]         sck_sync;
  logic [1:0]         sdi_sync;
  logic               cs_q;
  logic               sck_q;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cs_s;
  logic               sck_s;
  logic               sdi_s;
  logic               sck_rise;
  logic               cs_rise;
  logic               src_ok;
  logic               len_ok;

  assign cs_s     = cs_sync[1];
  assign sck_s    = sck_sync[1];
  assign sdi_s    = sdi_sync[1];
  assign sck_rise = sck_s & ~sck_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign len_ok   = (cnt_q == CNT_W'(FRAME_W));

  // Range check only needed when SEL_W can encode more sources than exist.
  if ((64'(1) << SEL_W) <= 64'(N_IN)) begin : g_src_full
    assign src_ok = 1'b1;
  end else begin : g_src_chk
    assign src_ok = (32'(shift_q[SRC_LSB +: SEL_W]) < N_IN);
  end

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= 2'b11;
      sck_sync <= 2'b00;
      sdi_sync <= 2'b00;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], cfg_cs_n};
      sck_sync <= {sck_sync[0], cfg_sck};
      sdi_sync <= {sdi_sync[0], cfg_sdi};
      cs_q     <= cs_s;
      sck_q    <= sck_s;
    end
  end

  // Shift in on SCK rise while selected; count saturates one past a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (cs_s) begin
      cnt_q <= '0;
    end else if (sck_rise) begin
      shift_q <= {shift_q[FRAME_W-2:0], sdi_s};
      if (cnt_q != CNT_W'(CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Judge the frame when chip select is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_oidx  <= '0;
      frame_en    <= 1'b0;
      frame_src   <= '0;
    end else begin
      frame_valid <= cs_rise & len_ok & src_ok;
      frame_err   <= cs_rise & ~(len_ok & src_ok);
      if (cs_rise) begin
        frame_oidx <= shift_q[OIDX_LSB +: OIDX_W];
        frame_en   <= shift_q[EN_POS];
        frame_src  <= shift_q[SRC_LSB +: SEL_W];
      end
    end
  end

endmodule

// File: rtl/modboard_route_ctrl.sv
// N_IN x N_OUT pin router with serially configured, break-before-make routes.
module modboard_route_ctrl
  import modboard_route_pkg::*;
#(
  parameter int unsigned N_IN     = N_IN_DEF,
  parameter int unsigned N_OUT    = N_OUT_DEF,
  parameter int unsigned SEL_W    = clog2(N_IN),
  parameter int unsigned OIDX_W   = clog2(N_OUT),
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_cs_n,
  input  logic             cfg_sck,
  input  logic             cfg_sdi,
  input  logic             err_clr,
  input  logic [N_IN-1:0]  pins_in,
  output logic [N_OUT-1:0] pins_out,
  output logic [N_OUT-1:0] pins_oe,
  output logic             busy,
  output logic             cfg_err,
  output logic             cfg_ovf
);

  localparam int unsigned DC_W = (clog2(DEAD_CYC) > 0) ? clog2(DEAD_CYC) : 1;

  logic              rx_valid;
  logic              rx_err;
  logic [OIDX_W-1:0] rx_oidx;
  logic              rx_en;
  logic [SEL_W-1:0]  rx_src;

  logic              pend_full;
  logic [OIDX_W-1:0] pend_oidx;
  logic              pend_en;
  logic [SEL_W-1:0]  pend_src;
  logic              pop;

  route_state_t      state;
  logic [OIDX_W-1:0] w_oidx;
  logic              w_en;
  logic [SEL_W-1:0]  w_src;
  logic [DC_W-1:0]   dead_cnt;
  logic [SEL_W-1:0]  sel [N_OUT];

  modboard_route_spi_rx #(
    .N_IN   (N_IN),
    .SEL_W  (SEL_W),
    .OIDX_W (OIDX_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_cs_n    (cfg_cs_n),
    .cfg_sck     (cfg_sck),
    .cfg_sdi     (cfg_sdi),
    .frame_valid (rx_valid),
    .frame_err   (rx_err),
    .frame_oidx  (rx_oidx),
    .frame_en    (rx_en),
    .frame_src   (rx_src)
  );

  assign pop = (state == IDLE) && pend_full;

  // One-deep pending slot; a post in the pop cycle refills it without overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_oidx <= '0;
      pend_en   <= 1'b0;
      pend_src  <= '0;
    end else if (rx_valid) begin
      pend_full <= 1'b1;
      pend_oidx <= rx_oidx;
      pend_en   <= rx_en;
      pend_src  <= rx_src;
    end else if (pop) begin
      pend_full <= 1'b0;
    end
  end

  // Sticky flags; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      cfg_ovf <= 1'b0;
    end else begin
      if (rx_err)       cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
      if (rx_valid && pend_full && !pop) cfg_ovf <= 1'b1;
      else if (err_clr)                  cfg_ovf <= 1'b0;
    end
  end

  // Break/dead/make sequencer; touches only the addressed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      w_oidx   <= '0;
      w_en     <= 1'b0;
      w_src    <= '0;
      dead_cnt <= '0;
      pins_oe  <= '0;
      for (int k = 0; k < int'(N_OUT); k++) sel[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_full) begin
            w_oidx <= pend_oidx;
            w_en   <= pend_en;
            w_src  <= pend_src;
            busy   <= 1'b1;
            state  <= BREAK;
          end
        end
        BREAK: begin
          pins_oe[w_oidx] <= 1'b0;
          dead_cnt        <= DC_W'(DEAD_CYC - 1);
          state           <= DEAD;
        end
        DEAD: begin
          if (dead_cnt == '0) state <= MAKE;
          else                dead_cnt <= dead_cnt - DC_W'(1);
        end
        MAKE: begin
          sel[w_oidx]     <= w_src;
          pins_oe[w_oidx] <= w_en;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational output mux; disabled outputs drive 0.
  always_comb begin
    pins_out = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      pins_out[k] = pins_oe[k] ? pins_in[sel[k]] : 1'b0;
    end
  end

endmodule

// File: tb/tb_modboard_route_ctrl.sv
// Randomised and directed bench for modboard_route_ctrl against a route-level model.
`timescale 1ns/1ps
module tb_modboard_route_ctrl;

  localparam int unsigned N_IN   = 8;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned OIDX_W = 2;
  // Long dead time so two whole frames fit inside one sequence (overflow case).
  localparam int unsigned DEAD   = 80;

  typedef struct {
    logic [OIDX_W-1:0] oidx;
    logic              en;
    logic [SEL_W-1:0]  src;
  } frm_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_cs_n = 1'b1;
  logic             cfg_sck = 1'b0;
  logic             cfg_sdi = 1'b0;
  logic             err_clr = 1'b0;
  logic [N_IN-1:0]  pins_in;
  logic [N_IN-1:0]  pins_fixed = '0;
  logic [N_IN-1:0]  pins_rnd = '0;
  logic             pins_rand = 1'b0;
  logic [N_OUT-1:0] pins_out;
  logic [N_OUT-1:0] pins_oe;
  logic             busy;
  logic             cfg_err;
  logic             cfg_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  frm_t             exp_q[$];
  logic [SEL_W-1:0] m_sel [N_OUT];
  logic [N_OUT-1:0] m_oe;

  assign pins_in = pins_rand ? pins_rnd : pins_fixed;

  modboard_route_ctrl #(
    .N_IN     (N_IN),
    .N_OUT    (N_OUT),
    .SEL_W    (SEL_W),
    .OIDX_W   (OIDX_W),
    .DEAD_CYC (DEAD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_cs_n (cfg_cs_n),
    .cfg_sck  (cfg_sck),
    .cfg_sdi  (cfg_sdi),
    .err_clr  (err_clr),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .pins_oe  (pins_oe),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .cfg_ovf  (cfg_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #2 pins_rnd = N_IN'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit-bang one frame MSB first, SCK period = 4 clk; push=1 queues the expected commit.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit push);
    frm_t f;
    cfg_cs_n = 1'b0;
    clks(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      cfg_sdi = data[i];
      clks(2);
      cfg_sck = 1'b1;
      clks(2);
      cfg_sck = 1'b0;
    end
    clks(2);
    cfg_cs_n = 1'b1;
    if (push) begin
      f.oidx = data[5:4];
      f.en   = data[3];
      f.src  = data[2:0];
      exp_q.push_back(f);
    end
    clks(1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
  endtask

  // Model: committed routes plus the in-flight frame; each sequence lasts DEAD+2
  // cycles from busy rising, and the addressed oe is low for the last DEAD+1.
  initial begin
    bit               active;
    bit               ended;
    int               phase;
    int               waitc;
    frm_t             cur;
    logic [N_OUT-1:0] e_oe;
    logic [N_OUT-1:0] e_out;
    active = 0;
    phase  = 0;
    waitc  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        active = 0;
        phase  = 0;
        waitc  = 0;
        exp_q.delete();
        m_oe = '0;
        for (int k = 0; k < int'(N_OUT); k++) m_sel[k] = '0;
        continue;
      end
      ended = 0;
      if (active) begin
        phase++;
        if (phase == int'(DEAD) + 2) begin
          m_sel[cur.oidx] = cur.src;
          m_oe[cur.oidx]  = cur.en;
          active = 0;
          ended  = 1;
        end
      end
      if (!active && !ended && busy === 1'b1 && exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        active = 1;
        phase  = 0;
        waitc  = 0;
      end
      if (!active && exp_q.size() > 0) begin
        waitc++;
        if (waitc > 40) begin
          check("commit_timeout_busy", 32'(busy), 32'(1));
          void'(exp_q.pop_front());
          waitc = 0;
        end
      end
      e_oe = m_oe;
      if (active && phase >= 1) e_oe[cur.oidx] = 1'b0;
      for (int k = 0; k < int'(N_OUT); k++) e_out[k] = e_oe[k] & pins_in[m_sel[k]];
      check("cyc_busy", 32'(busy), 32'(active));
      check("cyc_pins_oe", 32'(pins_oe), 32'(e_oe));
      check("cyc_pins_out", 32'(pins_out), 32'(e_out));
    end
  end

  initial begin
    int lowc;
    int guard;
    bit seen;

    // Reset state
    clks(3);
    check("rst_pins_oe", 32'(pins_oe), 32'(0));
    check("rst_pins_out", 32'(pins_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_cfg_ovf", 32'(cfg_ovf), 32'(0));
    rst_n = 1'b1;
    clks(5);

    // Route setup: out1 <- in5
    pins_fixed = 8'b0010_0000;
    send_frame(8'b01_1_101, 6, 1'b1);
    clks(DEAD + 20);
    check("setup_oe", 32'(pins_oe), 32'h2);
    check("setup_out_hi", 32'(pins_out), 32'h2);
    pins_fixed = 8'b0000_0000;
    #1 check("setup_out_lo", 32'(pins_out), 32'h0);
    clks(1);
    pins_fixed = 8'b0010_0000;
    #1 check("setup_out_hi2", 32'(pins_out), 32'h2);
    clks(1);

    // Break-before-make: out1 in5 -> in2 with both high
    pins_fixed = 8'b0010_0100;
    send_frame(8'b01_1_010, 6, 1'b1);
    seen = 0;
    for (guard = 0; guard < 40 && !seen; guard++) begin
      @(negedge clk); #1;
      if (pins_out[1] == 1'b0) seen = 1;
    end
    lowc = 0;
    if (seen) begin
      lowc = 1;
      for (guard = 0; guard < int'(DEAD) + 20; guard++) begin
        @(negedge clk); #1;
        if (pins_out[1] == 1'b1) break;
        lowc++;
      end
    end
    check("bbm_low_cycles", 32'(lowc), 32'(DEAD + 1));
    clks(5);
    check("bbm_out_after", 32'(pins_out), 32'h2);
    pins_fixed = 8'b0010_0000;
    #1 check("bbm_now_follows_in2", 32'(pins_out), 32'h0);
    clks(1);

    // Malformed frames
    send_frame(8'b01_1_00, 5, 1'b0);
    clks(20);
    check("short_err", 32'(cfg_err), 32'(1));
    check("short_oe_kept", 32'(pins_oe), 32'h2);
    pulse_clr();
    check("short_clr", 32'(cfg_err), 32'(0));
    send_frame(8'b0_01_1_001, 7, 1'b0);
    clks(20);
    check("long_err", 32'(cfg_err), 32'(1));
    check("long_oe_kept", 32'(pins_oe), 32'h2);
    pulse_clr();
    check("long_clr", 32'(cfg_err), 32'(0));
    check("no_ovf_yet", 32'(cfg_ovf), 32'(0));

    // Overflow: X starts a sequence, A and B both arrive while it runs
    send_frame(8'b01_1_101, 6, 1'b1);
    send_frame(8'b00_1_011, 6, 1'b0);
    send_frame(8'b10_1_111, 6, 1'b1);
    clks(DEAD + 60);
    check("ovf_set", 32'(cfg_ovf), 32'(1));
    check("ovf_err_clean", 32'(cfg_err), 32'(0));
    check("ovf_oe", 32'(pins_oe), 32'h6);
    pins_fixed = 8'h80;
    #1 check("ovf_out2_in7", 32'(pins_out), 32'h4);
    clks(1);
    pins_fixed = 8'h08;
    #1 check("ovf_out0_untouched", 32'(pins_out), 32'h0);
    clks(1);
    pulse_clr();
    check("ovf_clr", 32'(cfg_ovf), 32'(0));

    // Disable out3
    send_frame(8'b11_1_001, 6, 1'b1);
    clks(DEAD + 20);
    check("dis_pre_oe", 32'(pins_oe), 32'he);
    send_frame(8'b11_0_000, 6, 1'b1);
    clks(DEAD + 20);
    check("dis_oe", 32'(pins_oe), 32'h6);
    pins_fixed = 8'hff;
    #1 check("dis_out", 32'(pins_out), 32'h6);
    clks(1);

    // Reset mid-sequence
    send_frame(8'b00_1_100, 6, 1'b1);
    seen = 0;
    for (guard = 0; guard < 30 && !seen; guard++) begin
      @(negedge clk); #1;
      if (busy) seen = 1;
    end
    check("midrst_busy_seen", 32'(seen), 32'(1));
    clks(3);
    rst_n = 1'b0;
    #1;
    check("midrst_oe", 32'(pins_oe), 32'h0);
    check("midrst_out", 32'(pins_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'(0));
    clks(2);
    rst_n = 1'b1;
    clks(5);

    // Random frames against the model
    pins_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        int nb;
        nb = int'($urandom_range(1, 7));
        if (nb >= 6) nb++;
        send_frame(8'($urandom), nb, 1'b0);
        clks(20);
        check("rnd_bad_err", 32'(cfg_err), 32'(1));
        pulse_clr();
        check("rnd_bad_clr", 32'(cfg_err), 32'(0));
      end else begin
        logic [7:0] d;
        d = {2'b00, 6'($urandom)};
        send_frame(d, 6, 1'b1);
        clks(DEAD + 15);
      end
    end
    check("rnd_no_ovf", 32'(cfg_ovf), 32'(0));
    check("rnd_idle", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modboard_route_ctrl.md
Name: modboard_route_ctrl

Overview:
- Configurable pin router for the modboard CPLD. Generalises the fixed one-input-to-one-output pin connection into an N_IN x N_OUT routing matrix.
- An external MCU writes routes over a 3-wire serial port. The block commits each route with a break-before-make sequence, so no output ever glitches between two sources.
- Sits at the CPLD top level, between the board connector pins and the MCU config header.

Parameters:
- N_IN, 8, number of routable input pins.
- N_OUT, 4, number of routable output pins.
- SEL_W, 3, source-select width; equals clog2(N_IN).
- OIDX_W, 2, output-index width; equals clog2(N_OUT).
- DEAD_CYC, 4, clk cycles an output stays disabled between break and make; must be at least 1.

Ports:
- clk  in  1  system clock; must run at least 4x cfg_sck.
- rst_n  in  1  asynchronous active-low reset.
- cfg_cs_n  in  1  serial chip select, active low, asynchronous to clk.
- cfg_sck  in  1  serial clock; data is sampled on its rising edge; asynchronous to clk.
- cfg_sdi  in  1  serial data, MSB first.
- err_clr  in  1  single-cycle pulse that clears cfg_err and cfg_ovf.
- pins_in  in  N_IN  routable source pins.
- pins_out  out  N_OUT  routed outputs; a disabled output drives 0.
- pins_oe  out  N_OUT  per-output enable, intended for the pad tristate.
- busy  out  1  high while a break/dead/make sequence is in progress.
- cfg_err  out  1  sticky error: malformed frame or out-of-range select.
- cfg_ovf  out  1  sticky overflow: a pending frame was overwritten.

Behaviour:
- Reset values (async, rst_n low): sel[*]=0, pins_oe=0, pins_out=0, busy=0, cfg_err=0, cfg_ovf=0, pending slot empty, FSM in IDLE, shift register and bit count cleared.
- Datapath is combinational: pins_out[k] = pins_oe[k] ? pins_in[sel[k]] : 0. There is no clk latency from pins_in to pins_out.
- Synchronisers: cfg_cs_n, cfg_sck and cfg_sdi each pass through a 2-FF synchroniser. SCK rising edges are detected on the synchronised signal.
- Frame format: FRAME_W = OIDX_W+1+SEL_W bits (6 at defaults), sent MSB first.
  - Field order: out_idx[OIDX_W], en[1], src[SEL_W].
- Bit reception: on each detected SCK rise while CS is low, shift in SDI and increment the bit count, saturating at FRAME_W+1.
- Frame acceptance, on the synchronised CS rising edge:
  - count == FRAME_W and src < N_IN: the frame is valid and is posted to the pending slot.
  - Any other count, or src >= N_IN: frame is discarded, cfg_err is set.
  - The bit count clears whenever CS is high.
- Pending slot: one deep.
  - If a valid frame arrives while the slot is already full, the new frame overwrites it and cfg_ovf is set.
  - The FSM pops the slot in IDLE.
- FSM states and transitions:
  - IDLE: pending slot full -> latch frame into work regs, clear slot, go to BREAK. Otherwise stay.
  - BREAK (1 cycle): pins_oe[out_idx] <= 0; load dead counter with DEAD_CYC-1; go to DEAD.
  - DEAD: count down; at 0 go to MAKE.
  - MAKE (1 cycle): sel[out_idx] <= src; pins_oe[out_idx] <= en; go to IDLE.
  - busy = (state != IDLE).
  - Total sequence is DEAD_CYC+2 cycles from leaving IDLE to returning to IDLE. The oe low window on the affected output is exactly DEAD_CYC+1 cycles.
- Unchanged frames: a frame identical to the current sel/oe still executes the full sequence (deliberate re-arm). Only the addressed output is touched; other outputs are never disturbed.
- Disable frames: en=0 behaves the same, but the output stays disabled after MAKE and sel is still updated.
- Simultaneous events:
  - Slot post and FSM pop in the same cycle: the pop takes the old frame and the new frame stays pending; cfg_ovf is not set.
  - err_clr coinciding with a new error: set wins.
- Reset mid-sequence: immediate return to reset values. All outputs are disabled, and a partially received frame is lost.
- cs_n glitch shorter than the synchroniser: ignored. No requirement beyond counting detected edges.

Decomposition:
- Package modboard_route_pkg holds:
  - FSM state enum: IDLE, BREAK, DEAD, MAKE.
  - Frame field offsets and the FRAME_W calculation function.
  - clog2 helper.
- One sub-module, modboard_route_spi_rx: synchronisers, edge detect, shift register, bit count and frame-valid/frame-error pulses.
- The FSM, pending slot, routing registers and output mux stay in the top module.

Test Plan:
- Reset: assert rst_n low mid-sequence -> pins_oe=0, pins_out=0, busy=0 within the same cycle, with no clk edge needed.
- Route setup: send frame 01_1_101 (out1 <- in5, en) -> busy for 6 clk. pins_oe[1] goes high in MAKE. Then toggling pins_in[5] is mirrored on pins_out[1] combinationally; other outputs stay 0.
- Break-before-make: out1 routed to in5; send 01_1_010 with in5=1, in2=1 -> pins_out[1] is 0 for exactly 5 clk between the two high phases. No cycle exists where out1 follows in2 while oe was never dropped.
- Malformed frames:
  - 5-bit frame -> cfg_err=1, routing unchanged.
  - 7-bit frame -> cfg_err=1.
  - Then err_clr pulse -> cfg_err=0.
- Overflow: while busy, send frames A (00_1_011) and B (10_1_111) -> cfg_ovf=1. A is discarded; after completion out0 is unchanged and out2 <- in7.
- Disable: send 11_0_000 to an enabled out3 -> pins_oe[3]=0 permanently after the sequence, pins_out[3]=0 regardless of pins_in.
